// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid handshake and hands instructions to decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    input  logic        redirect,
    input  logic [31:0] redirect_pc,

    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic [31:0] target;
    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = target;
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect) pc_d = target;
                if (imem_gnt) begin
                    // A redirect racing the grant means the granted word is stale.
                    drop_d  = redirect;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid && (drop_q || redirect)) begin
                    drop_d  = 1'b0;
                    if (redirect) pc_d = target;
                    state_d = S_REQ;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_HOLD;
                end else if (redirect) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect || instr_ready) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (redirect) pc_d = target;
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a behavioural memory responder, a
// PC-stream reference queue, and a monitor that checks every accepted instruction.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    logic [31:0] exp_q[$];      // head = PC of the next instruction decode must see
    int          gnt_delay = 0; // REQ cycles before grant
    int          rv_lat    = 1; // cycles from grant to rvalid (>= 1)
    bit          rand_mem  = 1'b0;
    logic [31:0] key       = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Memory responder: grant after gnt_delay REQ cycles, data rv_lat cycles later.
    initial begin : memory
        logic        fire_gnt;
        logic [31:0] fire_addr;
        logic        pending;
        logic [31:0] paddr;
        int          rv_cnt;
        int          req_cnt;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pending     = 1'b0;
        paddr       = 32'h0;
        rv_cnt      = 0;
        req_cnt     = 0;
        forever begin
            @(negedge clk);
            fire_gnt  = imem_req && imem_gnt && !rst;
            fire_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (fire_gnt) begin
                pending = 1'b1;
                paddr   = fire_addr;
                rv_cnt  = rv_lat - 1;
                if (rand_mem) begin
                    gnt_delay = $urandom_range(0, 2);
                    rv_lat    = $urandom_range(1, 3);
                end
            end
            if (pending) begin
                if (rv_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pending     = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (imem_req) begin
                imem_gnt = (req_cnt >= gnt_delay);
                req_cnt++;
            end else begin
                req_cnt  = 0;
                imem_gnt = rand_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: protocol invariants every cycle, scoreboard on each handshake.
    initial begin : monitor
        logic        prev_hold;
        logic        prev_reqw;
        logic [31:0] prev_instr, prev_pc, prev_addr, e;
        prev_hold = 1'b0;
        prev_reqw = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                prev_reqw = 1'b0;
            end else begin
                check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
                if (!instr_valid) check("nop_when_empty", instr, NOP_INSTR);
                else              check("no_req_in_hold", {31'h0, imem_req}, 32'h0);
                if (prev_hold) begin
                    check("hold_valid", {31'h0, instr_valid}, 32'h1);
                    check("hold_instr", instr, prev_instr);
                    check("hold_pc", instr_pc, prev_pc);
                end
                if (prev_reqw) begin
                    check("req_held", {31'h0, imem_req}, 32'h1);
                    check("addr_held", imem_addr, prev_addr);
                end
                if (instr_valid && instr_ready && !redirect) begin
                    n_acc++;
                    check("exp_avail", exp_q.size(), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sb_pc", instr_pc, e);
                        check("sb_instr", instr, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                end
                prev_hold  = instr_valid && !instr_ready && !redirect;
                prev_reqw  = imem_req && !imem_gnt && !redirect;
                prev_instr = instr;
                prev_pc    = instr_pc;
                prev_addr  = imem_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
    endtask

    task automatic check_reset();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pc", instr_pc, RESET_PC);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        exp_q.delete();
        exp_q.push_back({t[31:2], 2'b00});
        step();
        redirect = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        if (!instr_valid) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        if (!imem_req) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (!(imem_req && imem_gnt) && n < 50) begin
            step();
            n++;
        end
        if (!(imem_req && imem_gnt)) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin : stimulus
        int n, acc0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        reset_model();
        step();
        step();
        check_reset();
        rst         = 1'b0;
        instr_ready = 1'b1;

        // Zero-wait memory, addr-as-data: latency 2, one instruction per 3 cycles.
        wait_req("first_req");
        wait_valid("lat_zero", n);
        check("lat_zero", n, 32'd2);
        acc0 = n_acc;
        repeat (9) step();
        check("throughput", n_acc - acc0, 32'd3);

        // Decode stall in HOLD.
        instr_ready = 1'b0;
        acc0 = n_acc;
        check("stall_pc", instr_pc, 32'h0000_000C);
        repeat (5) step();
        check("stall_hold_pc", instr_pc, 32'h0000_000C);
        check("stall_addr", imem_addr, 32'h0000_0010);
        check("stall_no_acc", n_acc - acc0, 32'd0);
        instr_ready = 1'b1;
        step();
        check("stall_release", n_acc - acc0, 32'd1);

        // Redirect in WAIT with low address bits set.
        wait_grant("rw_gnt");
        step();
        do_redirect(32'h0000_0103);
        wait_req("rw_req");
        check("redir_wait_addr", imem_addr, 32'h0000_0100);
        wait_valid("rw_valid", n);
        check("redir_wait_pc", instr_pc, 32'h0000_0100);

        // Redirect coinciding with grant; then redirect during HOLD.
        rv_lat = 2;
        step();
        wait_grant("rg_gnt");
        do_redirect(32'h0000_0200);
        wait_valid("rg_valid", n);
        check("redir_gnt_pc", instr_pc, 32'h0000_0200);
        do_redirect(32'h0000_0300);
        wait_valid("rh_valid", n);
        check("redir_hold_pc", instr_pc, 32'h0000_0300);

        // PC wraps past the top of the address space.
        step();
        do_redirect(32'hFFFF_FFFE);
        wait_valid("wrap_a", n);
        check("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_top_instr", instr, mem_word(32'hFFFF_FFFC));
        step();
        wait_valid("wrap_b", n);
        check("wrap_zero_pc", instr_pc, 32'h0000_0000);

        // Slow memory: 3 grant-wait cycles, data 2 cycles after grant.
        gnt_delay = 3;
        step();
        check("slow_req", {31'h0, imem_req}, 32'h1);
        wait_valid("lat_slow", n);
        check("lat_slow", n, 32'd6);

        // Reset pulse in WAIT; the response lands just after release.
        rv_lat = 3;
        step();
        wait_grant("rst_gnt");
        step();
        rst = 1'b1;
        #1;
        check_reset();
        reset_model();
        step();
        step();
        rst = 1'b0;
        wait_valid("post_rst", n);
        check("post_rst_pc", instr_pc, RESET_PC);
        check("post_rst_instr", instr, mem_word(RESET_PC));

        // Randomized traffic: stalls, redirects, variable memory latency.
        rst      = 1'b1;
        key      = 32'hC3A5_96E1;
        rand_mem = 1'b1;
        reset_model();
        step();
        step();
        rst  = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 4000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if (!redirect && $urandom_range(0, 15) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                exp_q.delete();
                exp_q.push_back({redirect_pc[31:2], 2'b00});
            end else begin
                redirect = 1'b0;
            end
            step();
        end
        redirect = 1'b0;
        check("rand_progress", 32'(n_acc - acc0 > 200), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
